pll_usb_reset_seq: RTL and testbench

//  Reset/lock sequencer for the USB PLL (48/54 MHz outputs), clocked from the free-running 50 MHz board

---
 rtl/pll_usb_reset_seq_pkg.sv | 20 ++
 rtl/pll_usb_sync.sv | 26 ++
 rtl/pll_usb_reset_seq.sv | 112 +++++++++++
 tb/tb_pll_usb_reset_seq.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pll_usb_reset_seq_pkg.sv
// Shared definitions for the USB PLL reset/lock sequencer: state encodings
// and the helper used to size the shared cycle counter.
package pll_usb_reset_seq_pkg;

    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3
    } seq_state_e;

    localparam logic [7:0] EVENT_CNT_MAX = 8'hFF;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pll_usb_sync.sv
// N-stage flip-flop synchronizer for a single asynchronous level, cleared
// to 0 by an asynchronous active-low reset.
module pll_usb_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // NOTE: the chain is a plain shift register, so resetting it is cheap and
    // keeps a stale "locked" from leaking into the sequencer after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_usb_reset_seq.sv
// Reset/lock sequencer for the USB PLL: pulses pll_rst, waits for a stable
// synchronized lock, then releases sys_reset_n; re-sequences on any fault.
module pll_usb_reset_seq
    import pll_usb_reset_seq_pkg::*;
#(
    parameter int PLL_RST_CYCLES = 50,
    parameter int LOCK_TIMEOUT   = 50000,
    parameter int STABLE_CYCLES  = 5000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pll_locked,
    input  logic       soft_rst,
    output logic       pll_rst,
    output logic       sys_reset_n,
    output logic       ready,
    output logic [2:0] state,
    output logic [7:0] retry_cnt,
    output logic [7:0] lock_loss_cnt
);

    localparam int CNT_W = $clog2(max3(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES) + 1);

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);

    seq_state_e       cur_state;
    seq_state_e       nxt_state;
    logic [CNT_W-1:0] cnt;
    logic             lk_s;
    logic             retry_inc;
    logic             loss_inc;

    pll_usb_sync #(.STAGES(SYNC_STAGES)) u_lock_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (pll_locked),
        .q       (lk_s)
    );

    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a value held and infer a latch.
    always_comb begin
        nxt_state = cur_state;
        retry_inc = 1'b0;
        loss_inc  = 1'b0;
        case (cur_state)
            ST_PLL_RST:   if (cnt == RST_LAST) nxt_state = ST_WAIT_LOCK;
            ST_WAIT_LOCK: begin
                if (lk_s) begin
                    nxt_state = ST_STABLE;
                end else if (cnt == TIMEOUT_LAST) begin
                    nxt_state = ST_PLL_RST;
                    retry_inc = 1'b1;
                end
            end
            ST_STABLE: begin
                if (!lk_s)                   nxt_state = ST_WAIT_LOCK;
                else if (cnt == STABLE_LAST) nxt_state = ST_RUN;
            end
            ST_RUN: begin
                if (!lk_s) begin
                    nxt_state = ST_PLL_RST;
                    loss_inc  = 1'b1;
                end
            end
            default:      nxt_state = ST_PLL_RST;
        endcase
        // A software request overrides everything and is not a counted fault.
        if (soft_rst) begin
            nxt_state = ST_PLL_RST;
            retry_inc = 1'b0;
            loss_inc  = 1'b0;
        end
    end

    // NOTE: all state here is sequential and uses non-blocking assignments, so
    // every register sees the pre-edge values of the others.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_state     <= ST_PLL_RST;
            cnt           <= '0;
            pll_rst       <= 1'b1;
            sys_reset_n   <= 1'b0;
            ready         <= 1'b0;
            retry_cnt     <= '0;
            lock_loss_cnt <= '0;
        end else begin
            cur_state   <= nxt_state;
            // Outputs decode the next state so they change together with it.
            pll_rst     <= (nxt_state == ST_PLL_RST);
            sys_reset_n <= (nxt_state == ST_RUN);
            ready       <= (nxt_state == ST_RUN);
            if (soft_rst || nxt_state != cur_state) begin
                cnt <= '0;
            end else if (cur_state != ST_RUN) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (retry_inc && retry_cnt != EVENT_CNT_MAX) begin
                retry_cnt <= retry_cnt + 8'd1;
            end
            if (loss_inc && lock_loss_cnt != EVENT_CNT_MAX) begin
                lock_loss_cnt <= lock_loss_cnt + 8'd1;
            end
        end
    end

    assign state = cur_state;

endmodule

// File: tb/tb_pll_usb_reset_seq.sv
// Directed bench for the USB PLL reset sequencer with short cycle parameters;
// inputs change and outputs are sampled on the falling clock edge.
module tb_pll_usb_reset_seq;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       pll_locked;
    logic       soft_rst;
    logic       pll_rst;
    logic       sys_reset_n;
    logic       ready;
    logic [2:0] state;
    logic [7:0] retry_cnt;
    logic [7:0] lock_loss_cnt;

    int total = 0;
    int bad   = 0;
    int glitch_seen = 0;
    int n;

    always #5 clk = ~clk;

    pll_usb_reset_seq #(
        .PLL_RST_CYCLES (4),
        .LOCK_TIMEOUT   (20),
        .STABLE_CYCLES  (8),
        .SYNC_STAGES    (2)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .pll_locked    (pll_locked),
        .soft_rst      (soft_rst),
        .pll_rst       (pll_rst),
        .sys_reset_n   (sys_reset_n),
        .ready         (ready),
        .state         (state),
        .retry_cnt     (retry_cnt),
        .lock_loss_cnt (lock_loss_cnt)
    );

    // sys_reset_n may only be high while the sequencer is in RUN.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && sys_reset_n !== 1'b0 && state !== 3'd3) glitch_seen++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int cycles = 1);
        repeat (cycles) @(negedge clk);
    endtask

    task automatic pulse_soft();
        soft_rst = 1'b1;
        tick();
        soft_rst = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] s, output int cycles);
        cycles = 0;
        while (state !== s && cycles < 100) begin
            tick();
            cycles++;
        end
    endtask

    task automatic wait_pll(input logic v, output int cycles);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (pll_rst !== v && cycles < 100);
    endtask

    initial begin
        reset_n    = 1'b0;
        pll_locked = 1'b0;
        soft_rst   = 1'b0;
        tick(2);
        check("rst_pll_rst", pll_rst, 1);
        check("rst_sys_reset_n", sys_reset_n, 0);
        check("rst_ready", ready, 0);
        check("rst_state", state, 0);
        check("rst_retry", retry_cnt, 0);
        check("rst_loss", lock_loss_cnt, 0);

        // Nominal bring-up.
        reset_n = 1'b1;
        wait_pll(1'b0, n);
        check("bringup_pll_rst_width", n, 4);
        check("bringup_wait_state", state, 1);
        tick(2);
        pll_locked = 1'b1;
        n = 0;
        while (sys_reset_n !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check("bringup_release_latency", n, 11);
        check("bringup_state", state, 3);
        check("bringup_ready", ready, 1);
        check("bringup_pll_rst_low", pll_rst, 0);

        // Lock loss in RUN.
        pll_locked = 1'b0;
        tick(2);
        check("loss_still_run", sys_reset_n, 1);
        tick();
        check("loss_sys_reset_n", sys_reset_n, 0);
        check("loss_ready", ready, 0);
        check("loss_pll_rst", pll_rst, 1);
        check("loss_state", state, 0);
        check("loss_cnt", lock_loss_cnt, 1);

        // One-cycle lock glitch during STABLE.
        pll_locked = 1'b1;
        wait_state(3'd2, n);
        check("glitch_reach_stable", state, 2);
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        tick(2);
        check("glitch_back_to_wait", state, 1);
        n = 0;
        while (state !== 3'd3 && n < 100) begin
            tick();
            n++;
        end
        check("glitch_relock_latency", n, 9);
        check("glitch_retry", retry_cnt, 0);

        // soft_rst in RUN.
        pulse_soft();
        check("soft_run_state", state, 0);
        check("soft_run_pll_rst", pll_rst, 1);
        check("soft_run_sys_reset_n", sys_reset_n, 0);
        check("soft_run_loss", lock_loss_cnt, 1);
        check("soft_run_retry", retry_cnt, 0);

        // soft_rst on the exact cycle STABLE would advance to RUN.
        wait_state(3'd2, n);
        tick(7);
        pulse_soft();
        check("soft_edge_state", state, 0);
        check("soft_edge_sys_reset_n", sys_reset_n, 0);
        check("soft_edge_ready", ready, 0);
        check("soft_edge_loss", lock_loss_cnt, 1);

        // soft_rst inside PLL_RST restarts the hold count.
        tick(2);
        pulse_soft();
        wait_pll(1'b0, n);
        check("soft_hold_restart", n, 4);

        // Lock timeout and retry.
        pll_locked = 1'b0;
        tick(3);
        pulse_soft();
        for (int k = 1; k <= 2; k++) begin
            wait_pll(1'b0, n);
            check("timeout_rst_width", n, 4);
            wait_pll(1'b1, n);
            check("timeout_wait_len", n, 20);
            check("timeout_retry", retry_cnt, k);
        end
        n = 0;
        while (retry_cnt !== 8'd255 && n < 7000) begin
            tick();
            n++;
        end
        tick(3 * 24);
        check("timeout_saturate", retry_cnt, 255);
        check("timeout_loss_unchanged", lock_loss_cnt, 1);

        // Async reset mid-WAIT_LOCK.
        wait_state(3'd1, n);
        #2 reset_n = 1'b0;
        #1;
        check("areset_wait_state", state, 0);
        check("areset_wait_pll_rst", pll_rst, 1);
        check("areset_wait_retry", retry_cnt, 0);
        check("areset_wait_loss", lock_loss_cnt, 0);
        @(negedge clk);
        reset_n    = 1'b1;
        pll_locked = 1'b1;
        wait_state(3'd3, n);
        check("areset_rerun", state, 3);
        pll_locked = 1'b0;
        tick(3);
        check("areset_loss_before", lock_loss_cnt, 1);
        pll_locked = 1'b1;
        wait_state(3'd3, n);

        // Async reset mid-RUN.
        #2 reset_n = 1'b0;
        #1;
        check("areset_run_sys_reset_n", sys_reset_n, 0);
        check("areset_run_ready", ready, 0);
        check("areset_run_pll_rst", pll_rst, 1);
        check("areset_run_state", state, 0);
        check("areset_run_loss", lock_loss_cnt, 0);
        @(negedge clk);
        reset_n = 1'b1;
        tick(2);

        check("no_sys_reset_glitch", glitch_seen, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
